calc_op_sequencer: RTL and testbench

- Front-end controller for the lab calculator datapath.
- Captures operand A, operand B and an opcode from the switches, one enter-button press at a time.
- Starts the ALU with a start/done handshake, then latches the 2*WIDTH-bit result.
- Drives the one-hot display-select code consumed by the result router (LED vs 7-seg), and lets the user cycle views.

---
 rtl/calc_op_sequencer_if.sv | 35 +++
 rtl/calc_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_op_sequencer_if.sv
// Front-panel / ALU handshake bundle for the calculator op sequencer.
// slave: sequencer side; master: switches, buttons and ALU side.
interface calc_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 2
) ();
  logic [WIDTH-1:0]   sw;
  logic               btn_enter;
  logic               btn_undo;
  logic               btn_view;
  logic               alu_done;
  logic [2*WIDTH-1:0] result_in;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [OP_W-1:0]    opcode;
  logic               alu_start;
  logic [2*WIDTH-1:0] result_q;
  logic [2*WIDTH-1:0] view_value;
  logic [3:0]         display_sel;
  logic [2:0]         state_q;

  modport slave (
    input  sw, btn_enter, btn_undo, btn_view,
    input  alu_done, result_in,
    output op_a, op_b, opcode, alu_start,
    output result_q, view_value, display_sel, state_q
  );

  modport master (
    output sw, btn_enter, btn_undo, btn_view,
    output alu_done, result_in,
    input  op_a, op_b, opcode, alu_start,
    input  result_q, view_value, display_sel, state_q
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Operand/opcode entry FSM with ALU start/done handshake and view select.
// Optional SEQ_IDLE_TIMEOUT_EN: SHOW auto-clears after TIMEOUT_CYC idle cycles.
module calc_op_sequencer #(
  parameter int WIDTH       = 16,
  parameter int OP_W        = 2,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic               clk,
  input  logic               reset_n,
  calc_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_e;

  localparam int RW = 2 * WIDTH;

  state_e          state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [OP_W-1:0]  opcode_q;
  logic             alu_start_q;
  logic [RW-1:0]    result_q;
  logic [3:0]       sel_q;
  logic [3:0]       sel_d;
  logic [RW-1:0]    view_d;

  logic ent_q, und_q, vw_q;
  logic ent_e, und_e, vw_e;
  logic ent_p, und_p, vw_p;

  assign ent_e = bus.btn_enter & ~ent_q;
  assign und_e = bus.btn_undo & ~und_q;
  assign vw_e  = bus.btn_view & ~vw_q;

  // Losing presses in a tie are dropped, never queued
  assign ent_p = ent_e;
  assign und_p = und_e & ~ent_e;
  assign vw_p  = vw_e & ~ent_e & ~und_e;

  // 0001 -> 0010 -> 0100 -> 1000 -> 0000 -> 0001
  assign sel_d = (sel_q == 4'b0000) ? 4'b0001
                                    : {sel_q[2:0], 1'b0};

`ifdef SEQ_IDLE_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] idle_q;
  logic        press_any;
  assign press_any = ent_e | und_e | vw_e;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= WAIT_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      alu_start_q <= 1'b0;
      result_q    <= '0;
      sel_q       <= 4'b0001;
      ent_q       <= 1'b0;
      und_q       <= 1'b0;
      vw_q        <= 1'b0;
`ifdef SEQ_IDLE_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      ent_q       <= bus.btn_enter;
      und_q       <= bus.btn_undo;
      vw_q        <= bus.btn_view;
      alu_start_q <= 1'b0;
`ifdef SEQ_IDLE_TIMEOUT_EN
      idle_q      <= '0;
`endif
      case (state_q)
        WAIT_A: begin
          sel_q <= 4'b0001;
          if (ent_p) begin
            op_a_q  <= bus.sw;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          sel_q <= 4'b0001;
          if (ent_p) begin
            op_b_q  <= bus.sw;
            state_q <= WAIT_OP;
          end else if (und_p) begin
            state_q <= WAIT_A;
          end
        end
        WAIT_OP: begin
          sel_q <= 4'b0001;
          if (ent_p) begin
            opcode_q    <= bus.sw[OP_W-1:0];
            alu_start_q <= 1'b1;
            state_q     <= EXEC;
          end else if (und_p) begin
            state_q <= WAIT_B;
          end
        end
        EXEC: begin
          sel_q <= 4'b0001;
          if (bus.alu_done) begin
            result_q <= bus.result_in;
            state_q  <= SHOW;
          end
        end
        SHOW: begin
          if (ent_p) begin
            state_q <= WAIT_A;
            sel_q   <= 4'b0001;
          end else if (vw_p) begin
            sel_q <= sel_d;
          end
`ifdef SEQ_IDLE_TIMEOUT_EN
          if (press_any) begin
            idle_q <= '0;
          end else if (idle_q == TMO_LAST) begin
            state_q  <= WAIT_A;
            result_q <= '0;
            sel_q    <= 4'b0001;
          end else begin
            idle_q <= idle_q + 32'd1;
          end
`endif
        end
        default: begin
          state_q <= WAIT_A;
          sel_q   <= 4'b0001;
        end
      endcase
    end
  end

  always_comb begin
    view_d = '0;
    case (state_q)
      WAIT_A,
      WAIT_B:  view_d = {{WIDTH{1'b0}}, bus.sw};
      WAIT_OP: view_d = {{WIDTH{1'b0}}, op_b_q};
      SHOW:    view_d = result_q;
      default: view_d = '0;
    endcase
  end

  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.opcode      = opcode_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.result_q    = result_q;
  assign bus.view_value  = view_d;
  assign bus.display_sel = sel_q;
  assign bus.state_q     = state_q;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboarded bench for calc_op_sequencer with a small multiply-ALU model.
// Define SEQ_IDLE_TIMEOUT_EN to also exercise the idle timeout.
module tb_calc_op_sequencer;
  logic clk;
  logic reset_n;

  calc_op_sequencer_if #(.WIDTH(16), .OP_W(2)) bus ();

  calc_op_sequencer #(
    .WIDTH(16), .OP_W(2), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int starts = 0;
  logic [31:0] sb_q[$];
  logic [2:0]  prev_st = 3'd0;

  logic        alu_auto = 1'b1;
  logic        done_auto = 1'b0;
  logic        done_man = 1'b0;
  logic [31:0] res_auto = '0;
  logic [31:0] res_man = '0;

  assign bus.alu_done  = done_auto | done_man;
  assign bus.result_in = done_man ? res_man : res_auto;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ALU model: done + product three cycles after start
  always begin
    @(negedge clk);
    if (alu_auto && bus.alu_start) begin
      repeat (2) @(negedge clk);
      res_auto  = 32'(bus.op_a) * 32'(bus.op_b);
      done_auto = 1'b1;
      @(negedge clk);
      done_auto = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.alu_start) starts <= starts + 1;
    if (bus.state_q == 3'd4 && prev_st != 3'd4) begin
      if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else chk("sb_result", 64'(bus.result_q), 64'(sb_q.pop_front()));
    end
    prev_st <= bus.state_q;
  end

  task automatic press(input int b, input logic [15:0] v);
    bus.sw = v;
    case (b)
      0:       bus.btn_enter = 1'b1;
      1:       bus.btn_undo  = 1'b1;
      default: bus.btn_view  = 1'b1;
    endcase
    @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_undo  = 1'b0;
    bus.btn_view  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_show();
    int k;
    k = 0;
    while (bus.state_q != 3'd4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.state_q != 3'd4) chk("show_wait", 64'(bus.state_q), 64'd4);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 64'(bus.state_q), 64'd0);
    chk({tag, "_op_a"}, 64'(bus.op_a), 64'd0);
    chk({tag, "_op_b"}, 64'(bus.op_b), 64'd0);
    chk({tag, "_opcode"}, 64'(bus.opcode), 64'd0);
    chk({tag, "_result"}, 64'(bus.result_q), 64'd0);
    chk({tag, "_start"}, 64'(bus.alu_start), 64'd0);
    chk({tag, "_sel"}, 64'(bus.display_sel), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] sel_exp[5];
    int s0;
    int n;
    sel_exp[0] = 4'b0010;
    sel_exp[1] = 4'b0100;
    sel_exp[2] = 4'b1000;
    sel_exp[3] = 4'b0000;
    sel_exp[4] = 4'b0001;

    bus.sw = '0;
    bus.btn_enter = 1'b0;
    bus.btn_undo  = 1'b0;
    bus.btn_view  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");

    // normal calculation
    press(0, 16'h0012);
    chk("a_state", 64'(bus.state_q), 64'd1);
    press(0, 16'h0034);
    chk("b_state", 64'(bus.state_q), 64'd2);
    chk("op_view", 64'(bus.view_value), 64'h34);
    s0 = starts;
    sb_q.push_back(32'h0000_03A8);
    press(0, 16'h0001);
    chk("exec_state", 64'(bus.state_q), 64'd3);
    chk("exec_view", 64'(bus.view_value), 64'd0);
    wait_show();
    chk("op_a", 64'(bus.op_a), 64'h12);
    chk("op_b", 64'(bus.op_b), 64'h34);
    chk("opcode", 64'(bus.opcode), 64'd1);
    chk("start_cycles", 64'(starts - s0), 64'd1);
    chk("show_sel", 64'(bus.display_sel), 64'd1);

    // view cycling
    for (int i = 0; i < 5; i++) begin
      press(2, 16'h0000);
      chk("view_sel", 64'(bus.display_sel), 64'(sel_exp[i]));
      chk("view_val", 64'(bus.view_value), 64'h3A8);
    end

    press(0, 16'h0000);
    chk("back_state", 64'(bus.state_q), 64'd0);
    chk("kept_result", 64'(bus.result_q), 64'h3A8);
    chk("back_sel", 64'(bus.display_sel), 64'd1);
    bus.sw = 16'hBEEF;
    @(negedge clk);
    chk("echo_view", 64'(bus.view_value), 64'hBEEF);

    // undo path
    press(1, 16'h0000);
    chk("undo_a", 64'(bus.state_q), 64'd0);
    press(0, 16'h0055);
    press(0, 16'h0066);
    press(1, 16'h0000);
    chk("undo_op", 64'(bus.state_q), 64'd1);
    press(0, 16'h0099);
    chk("redo_state", 64'(bus.state_q), 64'd2);
    chk("redo_op_b", 64'(bus.op_b), 64'h99);
    chk("redo_op_a", 64'(bus.op_a), 64'h55);
    sb_q.push_back(32'h0000_32CD);
    press(0, 16'hFFF6);
    wait_show();
    chk("trunc_opcode", 64'(bus.opcode), 64'd2);
    press(0, 16'h0000);

    // hold and priority
    bus.sw = 16'h0777;
    bus.btn_enter = 1'b1;
    repeat (50) @(negedge clk);
    bus.btn_enter = 1'b0;
    @(negedge clk);
    chk("hold_state", 64'(bus.state_q), 64'd1);
    chk("hold_op_a", 64'(bus.op_a), 64'h777);
    bus.sw = 16'h0888;
    bus.btn_enter = 1'b1;
    bus.btn_undo  = 1'b1;
    @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_undo  = 1'b0;
    @(negedge clk);
    chk("prio_state", 64'(bus.state_q), 64'd2);
    chk("prio_op_b", 64'(bus.op_b), 64'h888);

    // reset during EXEC, then stale done
    alu_auto = 1'b0;
    press(0, 16'h0003);
    chk("pre_rst_exec", 64'(bus.state_q), 64'd3);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    res_man  = 32'hDEAD_BEEF;
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid");
    alu_auto = 1'b1;

`ifdef SEQ_IDLE_TIMEOUT_EN
    press(0, 16'h0003);
    press(0, 16'h0004);
    sb_q.push_back(32'd12);
    press(0, 16'h0000);
    wait_show();
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.state_q == 3'd4) n++;
      else break;
    end
    chk("tmo_cycles", 64'(n), 64'd10);
    chk("tmo_state", 64'(bus.state_q), 64'd0);
    chk("tmo_result", 64'(bus.result_q), 64'd0);

    press(0, 16'h0005);
    press(0, 16'h0006);
    sb_q.push_back(32'd30);
    press(0, 16'h0000);
    wait_show();
    repeat (4) @(negedge clk);
    bus.btn_view = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.btn_view = 1'b0;
      if (bus.state_q == 3'd4) n++;
      else break;
    end
    chk("tmo_view_cycles", 64'(n), 64'd10);
    chk("tmo_view_result", 64'(bus.result_q), 64'd0);
`else
    n = 0;
    repeat (30) @(negedge clk);
    chk("idle_hold", 64'(bus.state_q + 3'(n)), 64'd0);
`endif

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
